dmem_arbiter: RTL

- Two-port arbiter and sequencer in front of the single-port data memory.
- Port 0 serves the core load/store path; port 1 serves a debug/DMA master.
- Arbitrates between the two, latches the winning request, drives the memory's write_en/read_en/funct3 for one cycle, then returns a done pulse and load data to the owner.
- Adds a range check that blocks accesses beyond the memory depth.

---
 rtl/dmem_arb_if.sv | 37 +++
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/dmem_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port data
// memory. The slave modport is the arbiter's view; master is everything else.
interface dmem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // requester side
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [2:0]        funct3_0, funct3_1;
    logic              gnt0, gnt1;
    logic              done0, done1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              err0, err1;
    // memory side
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_funct3;
    logic              mem_write_en, mem_read_en;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, funct3_0, funct3_1,
        output gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
        output mem_addr, mem_wdata, mem_funct3, mem_write_en, mem_read_en,
        input  mem_read_data
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, funct3_0, funct3_1,
        input  gnt0, gnt1, done0, done1, rdata0, rdata1, err0, err1,
        input  mem_addr, mem_wdata, mem_funct3, mem_write_en, mem_read_en,
        output mem_read_data
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single-port data memory.
// Port 0 = core load/store, port 1 = debug/DMA. One transaction every 3 cycles:
// IDLE (grant) -> ACCESS (memory enable) -> RESP (done + load data).
// Addresses >= MEM_WORDS never reach the memory and complete with err.
// Build option: DMEM_ARB_FIXED_PRIO_EN makes port 0 win every conflict;
// otherwise conflicts are resolved round robin on last_grant.
module dmem_arbiter #(
    parameter int MEM_WORDS = 1024,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32
) (
    input  logic      clk,
    input  logic      reset,
    dmem_arb_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // port index of the most recent grant
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic              oor_q, oor_d;                 // latched out-of-range flag
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              pick1;
    logic              grant_any;
    logic              sel_we;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_funct3;
    logic              done0, done1;
    logic              rd_ok;

    // Pick the winner among the live requests and mux its fields.
    always_comb begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pick1 = bus.req1 && !bus.req0;
`else
        pick1 = bus.req1 && (!bus.req0 || !last_grant_q);
`endif
        grant_any  = (state_q == IDLE) && !reset && (bus.req0 || bus.req1);
        sel_we     = pick1 ? bus.we1       : bus.we0;
        sel_addr   = pick1 ? bus.addr1     : bus.addr0;
        sel_wdata  = pick1 ? bus.wdata1    : bus.wdata0;
        sel_funct3 = pick1 ? bus.funct3_1  : bus.funct3_0;
        sel_oor    = sel_addr >= ADDR_W'(MEM_WORDS);
    end

    // Next-state: latch the winner in IDLE, fire memory in ACCESS, respond in RESP.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        oor_d        = oor_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    owner_d      = pick1;
                    last_grant_d = pick1;
                    we_d         = sel_we;
                    oor_d        = sel_oor;
                    addr_d       = sel_addr;
                    wdata_d      = sel_wdata;
                    funct3_d     = sel_funct3;
                    // enables are registered so they are high exactly in ACCESS
                    mem_we_d     = !sel_oor && sel_we;
                    mem_re_d     = !sel_oor && !sel_we;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                done_d  = 1'b1;
                err_d   = oor_q;
                state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // All state in one register bank; synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= '0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Reset also masks the enables and done in the cycle it is raised, so an
    // interrupted store never reaches the memory and no stale done leaks out.
    assign done0 = done_q && !owner_q && !reset;
    assign done1 = done_q &&  owner_q && !reset;
    assign rd_ok = !we_q && !oor_q;

    assign bus.gnt0   = grant_any && !pick1;
    assign bus.gnt1   = grant_any &&  pick1;
    assign bus.done0  = done0;
    assign bus.done1  = done1;
    assign bus.err0   = done0 && err_q;
    assign bus.err1   = done1 && err_q;
    // memory data is registered, so it is valid in RESP straight from the RAM
    assign bus.rdata0 = (done0 && rd_ok) ? bus.mem_read_data : '0;
    assign bus.rdata1 = (done1 && rd_ok) ? bus.mem_read_data : '0;

    assign bus.mem_addr     = addr_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.mem_funct3   = funct3_q;
    assign bus.mem_write_en = mem_we_q && !reset;
    assign bus.mem_read_en  = mem_re_q && !reset;

endmodule
